// File: rtl/ct_mmu_sysmap_arb_pkg.sv
// Shared widths and owner encoding for the MMU sysmap lookup arbiter.
package ct_mmu_sysmap_arb_pkg;

  localparam int PA_W_DEF = 28;
  localparam int FLG_W    = 5;
  localparam int HIT_W    = 8;

  typedef enum logic {
    OWNER_PTW  = 1'b0,
    OWNER_JTLB = 1'b1
  } owner_e;

endpackage

// File: rtl/ct_mmu_sysmap_rsp_slot.sv
// One requester's response slot: holds flg/hit until the requester acknowledges.
module ct_mmu_sysmap_rsp_slot
  import ct_mmu_sysmap_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [FLG_W-1:0] flg_in,
  input  logic [HIT_W-1:0] hit_in,
  input  logic             ack,
  input  logic             flush,
  output logic             vld,
  output logic [FLG_W-1:0] flg,
  output logic [HIT_W-1:0] hit
);

  // NOTE: the data fields are reset along with vld so outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      flg <= '0;
      hit <= '0;
    end else if (flush) begin
      vld <= 1'b0;
      flg <= '0;
      hit <= '0;
    end else if (load) begin
      // A result landing in the ack cycle replaces the old one without a bubble.
      vld <= 1'b1;
      flg <= flg_in;
      hit <= hit_in;
    end else if (ack && vld) begin
      vld <= 1'b0;
      flg <= '0;
      hit <= '0;
    end
  end

endmodule

// File: rtl/ct_mmu_sysmap_arb.sv
// Round-robin arbiter sharing one sysmap lookup between the page walker and the joint TLB.
module ct_mmu_sysmap_arb
  import ct_mmu_sysmap_arb_pkg::*;
#(
  parameter int PA_W = PA_W_DEF
) (
  input  logic             forever_cpuclk,
  input  logic             cpurst_b,
  input  logic             mmu_sysmap_flush,
  input  logic             ptw_sysmap_req_vld,
  input  logic [PA_W-1:0]  ptw_sysmap_pa,
  output logic             sysmap_ptw_grnt,
  output logic             sysmap_ptw_rsp_vld,
  output logic [FLG_W-1:0] sysmap_ptw_flg,
  output logic [HIT_W-1:0] sysmap_ptw_hit,
  input  logic             ptw_sysmap_rsp_ack,
  input  logic             jtlb_sysmap_req_vld,
  input  logic [PA_W-1:0]  jtlb_sysmap_pa,
  output logic             sysmap_jtlb_grnt,
  output logic             sysmap_jtlb_rsp_vld,
  output logic [FLG_W-1:0] sysmap_jtlb_flg,
  output logic [HIT_W-1:0] sysmap_jtlb_hit,
  input  logic             jtlb_sysmap_rsp_ack,
  output logic [PA_W-1:0]  mmu_sysmap_pa_y,
  input  logic [FLG_W-1:0] sysmap_mmu_flg_y,
  input  logic [HIT_W-1:0] sysmap_mmu_hit_y
);

  logic   arb_en;
  logic   s1_vld;
  owner_e s1_owner;
  owner_e rr_ptr;
  logic   ptw_elig;
  logic   jtlb_elig;
  logic   ptw_load;
  logic   jtlb_load;

  // arb_en keeps grants off until the first rising edge after reset release.
  assign ptw_elig  = ptw_sysmap_req_vld & arb_en & cpurst_b & ~mmu_sysmap_flush
                   & ~(s1_vld & (s1_owner == OWNER_PTW))
                   & (~sysmap_ptw_rsp_vld | ptw_sysmap_rsp_ack);
  assign jtlb_elig = jtlb_sysmap_req_vld & arb_en & cpurst_b & ~mmu_sysmap_flush
                   & ~(s1_vld & (s1_owner == OWNER_JTLB))
                   & (~sysmap_jtlb_rsp_vld | jtlb_sysmap_rsp_ack);

  assign sysmap_ptw_grnt  = ptw_elig  & (~jtlb_elig | (rr_ptr == OWNER_PTW));
  assign sysmap_jtlb_grnt = jtlb_elig & (~ptw_elig  | (rr_ptr == OWNER_JTLB));

  // NOTE: all state below uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      arb_en          <= 1'b0;
      s1_vld          <= 1'b0;
      s1_owner        <= OWNER_PTW;
      rr_ptr          <= OWNER_PTW;
      mmu_sysmap_pa_y <= '0;
    end else begin
      arb_en <= 1'b1;
      s1_vld <= sysmap_ptw_grnt | sysmap_jtlb_grnt;
      if (sysmap_jtlb_grnt) begin
        s1_owner        <= OWNER_JTLB;
        mmu_sysmap_pa_y <= jtlb_sysmap_pa;
      end else if (sysmap_ptw_grnt) begin
        s1_owner        <= OWNER_PTW;
        mmu_sysmap_pa_y <= ptw_sysmap_pa;
      end
      // Only a contested grant moves the pointer, and always to the loser.
      if (ptw_elig && jtlb_elig) begin
        if (rr_ptr == OWNER_PTW) rr_ptr <= OWNER_JTLB;
        else                     rr_ptr <= OWNER_PTW;
      end
    end
  end

  assign ptw_load  = s1_vld & (s1_owner == OWNER_PTW)  & ~mmu_sysmap_flush;
  assign jtlb_load = s1_vld & (s1_owner == OWNER_JTLB) & ~mmu_sysmap_flush;

  ct_mmu_sysmap_rsp_slot u_ptw_slot (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .load   (ptw_load),
    .flg_in (sysmap_mmu_flg_y),
    .hit_in (sysmap_mmu_hit_y),
    .ack    (ptw_sysmap_rsp_ack),
    .flush  (mmu_sysmap_flush),
    .vld    (sysmap_ptw_rsp_vld),
    .flg    (sysmap_ptw_flg),
    .hit    (sysmap_ptw_hit)
  );

  ct_mmu_sysmap_rsp_slot u_jtlb_slot (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .load   (jtlb_load),
    .flg_in (sysmap_mmu_flg_y),
    .hit_in (sysmap_mmu_hit_y),
    .ack    (jtlb_sysmap_rsp_ack),
    .flush  (mmu_sysmap_flush),
    .vld    (sysmap_jtlb_rsp_vld),
    .flg    (sysmap_jtlb_flg),
    .hit    (sysmap_jtlb_hit)
  );

endmodule
